rejunity_decoder: RTL and testbench

Combinational-core, output-registered unpacker for compact low-bit weight codes, wrapped in the standard Tiny Tapeout user-module pinout. In ternary mode one input byte (0..242) expands to five trits in {-1,0,+1}. In septenary mode a 6-bit code (0..48) expands to two digits in {-3..+3}. Results appear one clock after sampling, and an invalid flag marks out-of-range codes. It is the top-level user module of the tile.

---
 rtl/rejunity_decoder.sv | 103 ++++++++++
 tb/tb_rejunity_decoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rejunity_decoder.sv
// rejunity_decoder: unpacks compact low-bit weight codes.
// Ternary mode expands one byte (0..242) into five 2-bit trits.
// Septenary mode expands a 6-bit code (0..48) into two 3-bit digits.
// The decode is purely combinational. The results are registered once,
// so each code appears on the outputs one clock after it is sampled.
module rejunity_decoder (
    input  logic       clk,
    input  logic       rst_n,     // active-high synchronous reset despite the TT pin name
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       mode;
    logic [5:0] sept_code;
    logic       tern_invalid;
    logic       sept_invalid;

    logic [1:0] tern_digit [5];
    logic [1:0] tern_trit  [5];
    logic [2:0] sept_digit [2];
    logic [2:0] sept_value [2];

    logic [7:0] uo_reg;
    logic [7:0] uo_next;
    logic [1:0] t4_reg;
    logic [1:0] t4_next;
    logic       invalid_reg;
    logic       invalid_next;

    // Mode bits 7:1 are reserved. Reduce them into a sink signal.
    logic       unused_bits;
    assign unused_bits = &{1'b0, uio_in[7:1]};

    assign mode         = uio_in[0];
    assign sept_code    = ui_in[5:0];
    assign tern_invalid = (ui_in > 8'd242);
    assign sept_invalid = (sept_code > 6'd48);

    // Base-3 digit extraction. Each digit is (C / 3^i) mod 3.
    // Digit value d maps to trit d-1: 0 -> 11, 1 -> 00, 2 -> 01.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_tern
            localparam int TERN_POW = 3 ** gi;
            assign tern_digit[gi] = 2'((ui_in / 8'(TERN_POW)) % 8'd3);
            assign tern_trit[gi]  = {tern_digit[gi] == 2'd0, tern_digit[gi] != 2'd1};
        end
    endgenerate

    // Base-7 digit extraction. The digit value d maps to d-3 in 3-bit
    // two's complement (mod 8). Out-of-range codes can produce a high
    // digit that gets truncated, but those codes are masked by sept_invalid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sept
            localparam int SEPT_POW = 7 ** gi;
            assign sept_digit[gi] = 3'((sept_code / 6'(SEPT_POW)) % 6'd7);
            assign sept_value[gi] = sept_digit[gi] - 3'd3;
        end
    endgenerate

    // Select the output fields for the sampled mode.
    // Invalid codes zero every digit field and raise the flag.
    always_comb begin
        uo_next      = 8'h00;
        t4_next      = 2'b00;
        invalid_next = 1'b0;
        if (!mode) begin
            if (tern_invalid) begin
                invalid_next = 1'b1;
            end else begin
                uo_next = {tern_trit[3], tern_trit[2], tern_trit[1], tern_trit[0]};
                t4_next = tern_trit[4];
            end
        end else begin
            if (sept_invalid) begin
                invalid_next = 1'b1;
            end else begin
                uo_next = {2'b00, sept_value[1], sept_value[0]};
            end
        end
    end

    // Output registers. Reset overrides ena. When ena is low, the registers hold.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            uo_reg      <= 8'h00;
            t4_reg      <= 2'b00;
            invalid_reg <= 1'b0;
        end else if (ena) begin
            uo_reg      <= uo_next;
            t4_reg      <= t4_next;
            invalid_reg <= invalid_next;
        end
    end

    assign uo_out  = uo_reg;
    assign uio_out = {3'b000, invalid_reg, t4_reg, 2'b00};
    assign uio_oe  = 8'b0001_1100;

endmodule

// File: tb/tb_rejunity_decoder.sv
// Directed and exhaustive bench for rejunity_decoder.
module tb_rejunity_decoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors;
    int miscompares;

    rejunity_decoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. It uses repeated division in int arithmetic
    // and returns {uio_out, uo_out}.
    function automatic logic [15:0] model(input int code, input bit m);
        logic [7:0] uo;
        logic [7:0] uio;
        logic [1:0] trit;
        int         c;
        int         d;
        int         v;
        logic [2:0] v3;
        uo  = 8'h00;
        uio = 8'h00;
        if (!m) begin
            if (code > 242) begin
                uio[4] = 1'b1;
            end else begin
                c = code;
                for (int i = 0; i < 5; i++) begin
                    d = c % 3;
                    c = c / 3;
                    if (d == 2)      trit = 2'b01;
                    else if (d == 1) trit = 2'b00;
                    else             trit = 2'b11;
                    if (i < 4) uo[2*i +: 2] = trit;
                    else       uio[3:2] = trit;
                end
            end
        end else begin
            c = code % 64;
            if (c > 48) begin
                uio[4] = 1'b1;
            end else begin
                v  = (c % 7) - 3;
                v3 = v[2:0];
                uo[2:0] = v3;
                v  = (c / 7) - 3;
                v3 = v[2:0];
                uo[5:3] = v3;
            end
        end
        return {uio, uo};
    endfunction

    task automatic test_reset();
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'hFF;
        uio_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (uo_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_uo_out got=%02h exp=00", uo_out);
        end
        vectors++;
        if (uio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_uio_out got=%02h exp=00", uio_out);
        end
        vectors++;
        if (uio_oe !== 8'h1C) begin
            miscompares++;
            $display("FAIL reset_uio_oe got=%02h exp=1c", uio_oe);
        end
        $display("reset: uo_out=%02h uio_out=%02h uio_oe=%02h", uo_out, uio_out, uio_oe);
        rst_n = 1'b0;
    endtask

    task automatic test_ternary();
        logic [7:0] codes   [6] = '{8'd0,  8'd121, 8'd242, 8'd5,  8'd243, 8'd255};
        logic [7:0] exp_uo  [6] = '{8'hFF, 8'h00,  8'h55,  8'hF1, 8'h00,  8'h00};
        logic [7:0] exp_uio [6] = '{8'h0C, 8'h00,  8'h04,  8'h0C, 8'h10,  8'h10};
        for (int i = 0; i < 6; i++) begin
            ui_in  = codes[i];
            uio_in = 8'hAA;  // mode 0, junk in ignored bits
            @(posedge clk);
            #1;
            vectors++;
            if (uo_out !== exp_uo[i]) begin
                miscompares++;
                $display("FAIL ternary_uo code=%0d got=%02h exp=%02h", codes[i], uo_out, exp_uo[i]);
            end
            vectors++;
            if (uio_out !== exp_uio[i]) begin
                miscompares++;
                $display("FAIL ternary_uio code=%0d got=%02h exp=%02h", codes[i], uio_out, exp_uio[i]);
            end
            $display("ternary code=%0d uo_out=%02h uio_out=%02h", codes[i], uo_out, uio_out);
        end
    endtask

    task automatic test_septenary();
        logic [7:0] codes   [7] = '{8'd0,  8'd24, 8'd48, 8'd10, 8'hD8, 8'd49, 8'd63};
        logic [7:0] exp_uo  [7] = '{8'h2D, 8'h00, 8'h1B, 8'h30, 8'h00, 8'h00, 8'h00};
        logic [7:0] exp_uio [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10};
        for (int i = 0; i < 7; i++) begin
            ui_in  = codes[i];
            uio_in = 8'h55;  // mode 1, junk in ignored bits
            @(posedge clk);
            #1;
            vectors++;
            if (uo_out !== exp_uo[i]) begin
                miscompares++;
                $display("FAIL septenary_uo code=%0d got=%02h exp=%02h", codes[i], uo_out, exp_uo[i]);
            end
            vectors++;
            if (uio_out !== exp_uio[i]) begin
                miscompares++;
                $display("FAIL septenary_uio code=%0d got=%02h exp=%02h", codes[i], uio_out, exp_uio[i]);
            end
            $display("septenary code=%0d uo_out=%02h uio_out=%02h", codes[i], uo_out, uio_out);
        end
    endtask

    // Apply a new code each cycle. Before the edge the previous result must
    // still be showing. After the edge the new result must appear.
    task automatic test_back_to_back();
        logic [7:0] codes   [6] = '{8'd0,  8'd242, 8'd10, 8'd243, 8'd48, 8'd5};
        logic       modes   [6] = '{1'b0,  1'b0,   1'b1,  1'b0,   1'b1,  1'b0};
        logic [7:0] exp_uo  [6] = '{8'hFF, 8'h55,  8'h30, 8'h00,  8'h1B, 8'hF1};
        logic [7:0] exp_uio [6] = '{8'h0C, 8'h04,  8'h00, 8'h10,  8'h00, 8'h0C};
        for (int i = 0; i < 6; i++) begin
            ui_in  = codes[i];
            uio_in = {7'b0, modes[i]};
            if (i > 0) begin
                #1;
                vectors++;
                if (uo_out !== exp_uo[i-1]) begin
                    miscompares++;
                    $display("FAIL b2b_early idx=%0d got=%02h exp=%02h", i, uo_out, exp_uo[i-1]);
                end
            end
            @(posedge clk);
            #1;
            vectors++;
            if (uo_out !== exp_uo[i] || uio_out !== exp_uio[i]) begin
                miscompares++;
                $display("FAIL b2b idx=%0d got=%02h/%02h exp=%02h/%02h",
                         i, uo_out, uio_out, exp_uo[i], exp_uio[i]);
            end
            $display("b2b code=%0d mode=%0d uo_out=%02h uio_out=%02h", codes[i], modes[i], uo_out, uio_out);
        end
    endtask

    // This assumes the last result of back_to_back (code 5, ternary) is held: F1/0C.
    task automatic test_ena();
        logic [7:0] codes [3] = '{8'd121, 8'd242, 8'd0};
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ui_in  = codes[i];
            uio_in = {7'b0, i[0]};
            @(posedge clk);
            #1;
            vectors++;
            if (uo_out !== 8'hF1 || uio_out !== 8'h0C) begin
                miscompares++;
                $display("FAIL ena_hold edge=%0d got=%02h/%02h exp=f1/0c", i, uo_out, uio_out);
            end
            $display("ena=0 edge=%0d uo_out=%02h uio_out=%02h", i, uo_out, uio_out);
        end
        ena    = 1'b1;
        ui_in  = 8'd121;
        uio_in = 8'h00;
        @(posedge clk);
        #1;
        vectors++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL ena_resume got=%02h/%02h exp=00/00", uo_out, uio_out);
        end
        $display("ena=1 resume uo_out=%02h uio_out=%02h", uo_out, uio_out);
    endtask

    task automatic test_mode_toggle();
        logic [7:0] codes   [4] = '{8'd10,  8'd10,  8'd24,  8'd24};
        logic       modes   [4] = '{1'b0,   1'b1,   1'b0,   1'b1};
        logic [7:0] exp_uo  [4] = '{8'hCC,  8'h30,  8'hD7,  8'h00};
        logic [7:0] exp_uio [4] = '{8'h0C,  8'h00,  8'h0C,  8'h00};
        for (int i = 0; i < 4; i++) begin
            ui_in  = codes[i];
            uio_in = {7'b0, modes[i]};
            @(posedge clk);
            #1;
            vectors++;
            if (uo_out !== exp_uo[i] || uio_out !== exp_uio[i]) begin
                miscompares++;
                $display("FAIL mode_toggle idx=%0d got=%02h/%02h exp=%02h/%02h",
                         i, uo_out, uio_out, exp_uo[i], exp_uio[i]);
            end
            $display("toggle code=%0d mode=%0d uo_out=%02h uio_out=%02h", codes[i], modes[i], uo_out, uio_out);
        end
    endtask

    // Assert reset mid-stream with ena low. Reset must still win and discard the code.
    task automatic test_reset_midstream();
        ui_in  = 8'd0;
        uio_in = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ena   = 1'b0;
        ui_in = 8'd5;
        @(posedge clk);
        #1;
        vectors++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_midstream got=%02h/%02h exp=00/00", uo_out, uio_out);
        end
        $display("reset midstream uo_out=%02h uio_out=%02h", uo_out, uio_out);
        rst_n = 1'b0;
        ena   = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (uo_out !== 8'hF1 || uio_out !== 8'h0C) begin
            miscompares++;
            $display("FAIL post_reset_first got=%02h/%02h exp=f1/0c", uo_out, uio_out);
        end
        $display("post reset code=5 uo_out=%02h uio_out=%02h", uo_out, uio_out);
    endtask

    task automatic test_exhaustive();
        logic [15:0] exp;
        int          errs;
        for (int m = 0; m < 2; m++) begin
            errs = 0;
            for (int c = 0; c < 256; c++) begin
                ui_in  = 8'(c);
                uio_in = {7'b1100110, m[0]};
                exp    = model(c, m[0]);
                @(posedge clk);
                #1;
                vectors++;
                if (uo_out !== exp[7:0] || uio_out !== exp[15:8]) begin
                    miscompares++;
                    errs++;
                    $display("FAIL exhaustive mode=%0d code=%0d got=%02h/%02h exp=%02h/%02h",
                             m, c, uo_out, uio_out, exp[7:0], exp[15:8]);
                end
            end
            $display("exhaustive mode=%0d swept 256 codes, %0d bad", m, errs);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        ena         = 1'b1;
        ui_in       = 8'h00;
        uio_in      = 8'h00;
        test_reset();
        test_ternary();
        test_septenary();
        test_back_to_back();
        test_ena();
        test_mode_toggle();
        test_reset_midstream();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
